// File: rtl/board_game_pkg.sv
// Shared encodings for the board game controller.
//   Cell codes  : 2-bit per-cell contents on the packed board.
//   Who codes   : game result reported on the who output.
//   state_e     : controller FSM states.
//   dir_e       : win-check direction sequenced during CHECK.
package board_game_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  // Who codes deliberately equal the owner cell codes so a winner can be
  // reported by copying the owner of the last move.
  localparam logic [1:0] WHO_NONE      = 2'b00;
  localparam logic [1:0] WHO_PLAYER    = 2'b01;
  localparam logic [1:0] WHO_COMPUTER  = 2'b10;
  localparam logic [1:0] WHO_DRAW      = 2'b11;

  typedef enum logic [1:0] {
    P_TURN = 2'd0,
    C_TURN = 2'd1,
    CHECK  = 2'd2,
    OVER   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIR_ROW  = 2'd0,
    DIR_COL  = 2'd1,
    DIR_DIAG = 2'd2,
    DIR_ANTI = 2'd3
  } dir_e;

endpackage

// File: rtl/board_line_check.sv
// Counts the contiguous run of owner_i cells along one direction through
// pos_i (the cell itself included), stopping at board edges; rows never wrap.
//   board_i : packed board, cell i at [2i+1:2i]
//   pos_i   : row-major position of the last move
//   owner_i : cell code to match
//   dir_i   : 0 row, 1 column, 2 diagonal, 3 anti-diagonal
//   count_o : run length, 1..N
module board_line_check
  import board_game_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N*N),
  parameter int CW = $clog2(N+1)
) (
  input  logic [2*N*N-1:0] board_i,
  input  logic [PW-1:0]    pos_i,
  input  logic [1:0]       owner_i,
  input  logic [1:0]       dir_i,
  output logic [CW-1:0]    count_o
);

  logic [N*N-1:0][1:0] cells;
  assign cells = board_i;

  int          r0, c0, dr, dc, r, c;
  logic        fwd, bwd, inb;
  logic [PW-1:0] idx;

  always_comb begin
    r0      = int'(pos_i) / N;
    c0      = int'(pos_i) % N;
    dr      = 0;
    dc      = 1;
    r       = 0;
    c       = 0;
    inb     = 1'b0;
    idx     = '0;
    fwd     = 1'b1;
    bwd     = 1'b1;
    count_o = CW'(1);
    case (dir_i)
      DIR_ROW:  begin dr = 0; dc = 1;  end
      DIR_COL:  begin dr = 1; dc = 0;  end
      DIR_DIAG: begin dr = 1; dc = 1;  end
      default:  begin dr = 1; dc = -1; end
    endcase
    // Walk outward both ways; a walk stops for good at the first miss or edge.
    for (int d = 1; d < N; d++) begin
      r   = r0 + d*dr;
      c   = c0 + d*dc;
      inb = (r >= 0) && (r < N) && (c >= 0) && (c < N);
      idx = inb ? PW'(r*N + c) : '0;
      if (fwd && inb && cells[idx] == owner_i) count_o = count_o + 1'b1;
      else                                     fwd = 1'b0;
      r   = r0 - d*dr;
      c   = c0 - d*dc;
      inb = (r >= 0) && (r < N) && (c >= 0) && (c < N);
      idx = inb ? PW'(r*N + c) : '0;
      if (bwd && inb && cells[idx] == owner_i) count_o = count_o + 1'b1;
      else                                     bwd = 1'b0;
    end
  end

endmodule

// File: rtl/board_game_ctrl.sv
// N x N board game controller (player vs computer, K in a row wins).
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   play / pc         : player / computer move strobes
//   player_position,
//   computer_position : row-major target cells
//   board             : 2 bits per cell (00 empty, 01 player, 10 computer)
//   who               : 00 none, 01 player, 10 computer, 11 draw
//   turn              : 0 player to move, 1 computer to move
//   illegal           : one-cycle pulse for a rejected move
//   busy              : high during the 4-cycle win check
module board_game_ctrl
  import board_game_pkg::*;
#(
  parameter  int N  = 3,
  parameter  int K  = 3,
  localparam int PW = $clog2(N*N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            play,
  input  logic            pc,
  input  logic [PW-1:0]   player_position,
  input  logic [PW-1:0]   computer_position,
  output logic [2*N*N-1:0] board,
  output logic [1:0]      who,
  output logic            turn,
  output logic            illegal,
  output logic            busy
);

  localparam int NN = N*N;
  localparam int MW = $clog2(NN+1);
  localparam int CW = $clog2(N+1);

  if (N < 3 || N > 15 || K < 2 || K > N) begin : g_param_err
    $error("board_game_ctrl: N must be 3..15 and K must be 2..N");
  end

  state_e            state_q, state_d;
  logic [NN-1:0][1:0] cells_q, cells_d;
  logic [1:0]        who_q, who_d;
  logic              turn_q, turn_d;
  logic              illegal_q, illegal_d;
  logic [MW-1:0]     mcnt_q, mcnt_d;
  logic [PW-1:0]     last_q, last_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        dir_q, dir_d;
  logic              win_q, win_d;

  logic [CW-1:0]     run_cnt;
  logic              run_hit;
  logic              mv_strobe, mv_legal;
  logic [PW-1:0]     mv_pos;
  logic [1:0]        mv_code;

  // One checker, stepped through the four directions while in CHECK.
  board_line_check #(.N(N), .PW(PW), .CW(CW)) u_line (
    .board_i (cells_q),
    .pos_i   (last_q),
    .owner_i (owner_q),
    .dir_i   (dir_q),
    .count_o (run_cnt)
  );

  assign run_hit = int'(run_cnt) >= K;

  always_comb begin
    state_d   = state_q;
    cells_d   = cells_q;
    who_d     = who_q;
    turn_d    = turn_q;
    illegal_d = 1'b0;
    mcnt_d    = mcnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    dir_d     = dir_q;
    win_d     = win_q;
    // Only the strobe of the side to move is looked at.
    mv_strobe = (state_q == P_TURN) ? play : pc;
    mv_pos    = (state_q == P_TURN) ? player_position : computer_position;
    mv_code   = (state_q == P_TURN) ? CELL_PLAYER : CELL_COMPUTER;
    mv_legal  = (int'(mv_pos) < NN) && (cells_q[mv_pos] == CELL_EMPTY);
    unique case (state_q)
      P_TURN, C_TURN: begin
        if (mv_strobe) begin
          if (mv_legal) begin
            cells_d[mv_pos] = mv_code;
            last_d          = mv_pos;
            owner_d         = mv_code;
            mcnt_d          = mcnt_q + 1'b1;
            dir_d           = DIR_ROW;
            win_d           = 1'b0;
            state_d         = CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      CHECK: begin
        if (dir_q == DIR_ANTI) begin
          if (win_q || run_hit) begin
            who_d   = owner_q;
            state_d = OVER;
          end else if (int'(mcnt_q) == NN) begin
            who_d   = WHO_DRAW;
            state_d = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = turn_q ? P_TURN : C_TURN;
          end
        end else begin
          win_d = win_q | run_hit;
          dir_d = dir_q + 2'd1;
        end
      end
      OVER: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= P_TURN;
      cells_q   <= '0;
      who_q     <= WHO_NONE;
      turn_q    <= 1'b0;
      illegal_q <= 1'b0;
      mcnt_q    <= '0;
      last_q    <= '0;
      owner_q   <= CELL_EMPTY;
      dir_q     <= DIR_ROW;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cells_q   <= cells_d;
      who_q     <= who_d;
      turn_q    <= turn_d;
      illegal_q <= illegal_d;
      mcnt_q    <= mcnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      dir_q     <= dir_d;
      win_q     <= win_d;
    end
  end

  assign board   = cells_q;
  assign who     = who_q;
  assign turn    = turn_q;
  assign illegal = illegal_q;
  assign busy    = (state_q == CHECK);

endmodule

// File: tb/tb_board_game_ctrl.sv
// Scoreboard bench: two controllers (3x3 K=3 and 5x5 K=4). Each move pushes
// its expected outcome, computed by a whole-board reference model; monitors
// pop on illegal pulses and on the end of each busy window.
module tb_board_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        play_a = 0, pc_a = 0;
  logic [3:0]  ppos_a = 0, cpos_a = 0;
  logic [17:0] board_a;
  logic [1:0]  who_a;
  logic        turn_a, ill_a, busy_a;

  logic        play_b = 0, pc_b = 0;
  logic [4:0]  ppos_b = 0, cpos_b = 0;
  logic [49:0] board_b;
  logic [1:0]  who_b;
  logic        turn_b, ill_b, busy_b;

  board_game_ctrl #(.N(3), .K(3)) dut_a (
    .clock(clk), .reset(rst_n), .play(play_a), .pc(pc_a),
    .player_position(ppos_a), .computer_position(cpos_a),
    .board(board_a), .who(who_a), .turn(turn_a), .illegal(ill_a), .busy(busy_a)
  );

  board_game_ctrl #(.N(5), .K(4)) dut_b (
    .clock(clk), .reset(rst_n), .play(play_b), .pc(pc_b),
    .player_position(ppos_b), .computer_position(cpos_b),
    .board(board_b), .who(who_b), .turn(turn_b), .illegal(ill_b), .busy(busy_b)
  );

  typedef struct {
    bit          res;    // 0 illegal pulse, 1 end of check
    int          who;
    int          turn;
    logic [49:0] board;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int tests = 0;
  int fails = 0;

  // Reference model: plain arrays, game rules applied to the whole board.
  int mcells[2][25];
  int mmoves[2];
  int mturn[2];
  int mwho[2];
  bit mover[2];
  int nside[2] = '{3, 5};
  int krun[2]  = '{3, 4};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [49:0] pack(int b);
    logic [49:0] v = '0;
    for (int i = 0; i < nside[b]*nside[b]; i++)
      v = v | (50'(mcells[b][i]) << (2*i));
    return v;
  endfunction

  function automatic bit has_run(int b, int own);
    int n = nside[b];
    int k = krun[b];
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          bit all = 1'b1;
          for (int j = 0; j < k; j++) begin
            int rr = r + j*dr[d];
            int cc = c + j*dc[d];
            if (rr < 0 || rr >= n || cc < 0 || cc >= n || mcells[b][rr*n+cc] != own)
              all = 1'b0;
          end
          if (all) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 25; i++) mcells[b][i] = 0;
      mmoves[b] = 0; mturn[b] = 0; mwho[b] = 0; mover[b] = 1'b0;
    end
  endtask

  task automatic drive(int b, bit ps, bit cs, int pp, int cp);
    if (b == 0) begin
      play_a = ps; pc_a = cs; ppos_a = 4'(pp); cpos_a = 4'(cp);
    end else begin
      play_b = ps; pc_b = cs; ppos_b = 5'(pp); cpos_b = 5'(cp);
    end
    @(posedge clk); #1;
    play_a = 0; pc_a = 0; play_b = 0; pc_b = 0;
  endtask

  // Issue one strobe pair; optionally poke both strobes during the check.
  task automatic mv(int b, bit ps, bit cs, int pp, int cp, bit poke);
    exp_t e;
    int  n     = nside[b];
    bit  act   = (mturn[b] == 0) ? ps : cs;
    int  pos   = (mturn[b] == 0) ? pp : cp;
    int  own   = mturn[b] + 1;
    bit  legal = 1'b0;
    if (!mover[b] && act) begin
      if (pos >= n*n || mcells[b][pos] != 0) begin
        e.res = 1'b0;
      end else begin
        legal = 1'b1;
        mcells[b][pos] = own;
        mmoves[b]++;
        if (has_run(b, own)) begin
          mwho[b] = own; mover[b] = 1'b1;
        end else if (mmoves[b] == n*n) begin
          mwho[b] = 3; mover[b] = 1'b1;
        end else begin
          mturn[b] = 1 - mturn[b];
        end
        e.res = 1'b1;
      end
      e.who = mwho[b]; e.turn = mturn[b]; e.board = pack(b);
      if (b == 0) qa.push_back(e); else qb.push_back(e);
    end
    drive(b, ps, cs, pp, cp);
    if (legal && poke)
      drive(b, 1'b1, 1'b1, $urandom_range(0, n*n-1), $urandom_range(0, n*n-1));
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic evt(int b, bit res, logic [1:0] w, logic t, logic [49:0] bd);
    exp_t  e;
    string s = (b == 0) ? "A" : "B";
    int    sz = (b == 0) ? qa.size() : qb.size();
    tests++;
    if (sz == 0) begin
      fails++;
      $display("FAIL %s event kind %0d: got unexpected event, expected none", s, res);
    end else begin
      if (b == 0) e = qa.pop_front(); else e = qb.pop_front();
      chk({s, " event kind"}, 64'(res), 64'(e.res));
      chk({s, " who"},        64'(w),   64'(e.who));
      chk({s, " turn"},       64'(t),   64'(e.turn));
      chk({s, " board"},      64'(bd),  64'(e.board));
    end
  endtask

  int bca = 0, bcb = 0;
  bit bpa = 0, bpb = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bca = 0; bpa = 1'b0;
    end else begin
      if (ill_a) evt(0, 1'b0, who_a, turn_a, 50'(board_a));
      if (busy_a) bca++;
      if (bpa && !busy_a) begin
        chk("A busy length", 64'(bca), 64'd4);
        bca = 0;
        evt(0, 1'b1, who_a, turn_a, 50'(board_a));
      end
      bpa = busy_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      bcb = 0; bpb = 1'b0;
    end else begin
      if (ill_b) evt(1, 1'b0, who_b, turn_b, board_b);
      if (busy_b) bcb++;
      if (bpb && !busy_b) begin
        chk("B busy length", 64'(bcb), 64'd4);
        bcb = 0;
        evt(1, 1'b1, who_b, turn_b, board_b);
      end
      bpb = busy_b;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("A reset board",   64'(board_a), 64'd0);
    chk("A reset who",     64'(who_a),   64'd0);
    chk("A reset turn",    64'(turn_a),  64'd0);
    chk("A reset illegal", 64'(ill_a),   64'd0);
    chk("A reset busy",    64'(busy_a),  64'd0);
    chk("B reset board",   64'(board_b), 64'd0);
    chk("B reset busy",    64'(busy_b),  64'd0);
    model_reset();
    rst_n = 1'b1;
  endtask

  int seq34[9]  = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int seq37[12] = '{1, 8, 13, 16, 21, 12, 9, 0, 23, 6, 14, 18};

  initial begin
    model_reset();
    do_reset();

    // Player completes the top row.
    mv(0, 1, 0, 0, 0, 1);
    mv(0, 0, 1, 0, 4, 0);
    mv(0, 1, 0, 1, 0, 1);
    mv(0, 0, 1, 0, 8, 0);
    mv(0, 1, 0, 2, 0, 0);
    chk("A row win who",   64'(who_a),   64'd1);
    chk("A row win board", 64'(board_a), 64'h20215);
    mv(0, 1, 1, 3, 5, 0);
    chk("A over board held", 64'(board_a), 64'h20215);
    chk("A over who held",   64'(who_a),   64'd1);

    // Computer targets an occupied cell.
    do_reset();
    mv(0, 1, 0, 0, 0, 1);
    mv(0, 0, 1, 0, 0, 0);
    chk("A occupied turn", 64'(turn_a), 64'd1);

    // Full board with no line.
    do_reset();
    for (int i = 0; i < 9; i++)
      mv(0, (i % 2) == 0, (i % 2) == 1, seq34[i], seq34[i], 1'($urandom % 2));
    chk("A draw who", 64'(who_a), 64'd3);

    // Both strobes, player position off the board.
    do_reset();
    mv(0, 1, 1, 9, 4, 0);
    chk("A off-board board", 64'(board_a), 64'd0);
    chk("A off-board turn",  64'(turn_a),  64'd0);

    // Reset landing in the second check cycle.
    do_reset();
    drive(0, 1, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("A mid-check reset board", 64'(board_a), 64'd0);
    chk("A mid-check reset busy",  64'(busy_a),  64'd0);
    chk("A mid-check reset turn",  64'(turn_a),  64'd0);
    model_reset();
    rst_n = 1'b1;

    // 5x5 K=4: anti-diagonal of three, then a diagonal of four.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      mv(1, (i % 2) == 0, (i % 2) == 1, seq37[i], seq37[i], 1'b0);
      if (i == 9) chk("B no early win", 64'(who_b), 64'd0);
    end
    chk("B diagonal win", 64'(who_b), 64'd2);

    // Random games.
    for (int g = 0; g < 8; g++) begin
      int b = (g < 6) ? 0 : 1;
      int lim = (b == 0) ? 12 : 28;
      do_reset();
      for (int m = 0; m < 45 && !mover[b]; m++) begin
        bit ps = (mturn[b] == 0) ? ($urandom % 8 != 0) : ($urandom % 4 == 0);
        bit cs = (mturn[b] == 1) ? ($urandom % 8 != 0) : ($urandom % 4 == 0);
        mv(b, ps, cs, $urandom_range(0, lim-1), $urandom_range(0, lim-1), 1'($urandom % 2));
      end
      mv(b, 1, 1, 0, 1, 0);
      if (b == 0) begin
        chk("A random final board", 64'(board_a), 64'(pack(0)));
        chk("A random final who",   64'(who_a),   64'(mwho[0]));
      end else begin
        chk("B random final board", 64'(board_b), 64'(pack(1)));
        chk("B random final who",   64'(who_b),   64'(mwho[1]));
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("A pending expectations", 64'(qa.size()), 64'd0);
    chk("B pending expectations", 64'(qb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
